// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one 1-bit full-adder cell
// reused over WIDTH cycles, LSB first, carry held in a register.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request; accepted only in IDLE or DONE
//   sel       0 = add (a + b + cin), 1 = subtract (a - b)
//   cin       carry-in for add; ignored for subtract
//   a, b      WIDTH-bit operands, sampled when start is accepted
//   result    WIDTH-bit sum/difference, held until next completion
//   cout      final carry-out (subtract: 1 = no borrow)
//   overflow  two's-complement overflow
//   busy      high while bits are being processed
//   done      one-cycle pulse when result/cout/overflow update
//
// Build option: SERIAL_ADDSUB_OVF_EN enables overflow tracking;
// when undefined, overflow is tied to 0.

module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             c;

    logic load;
    logic last;
    logic sum;
    logic c_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        sum        = a_sr[0] ^ b_sr[0] ^ c;
        c_next     = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
        last       = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
        load       = start && ((state == IDLE) || (state == DONE));
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? SHIFT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Subtract is a + ~b + 1: B is inverted at load and the carry
    // register is seeded with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            acc    <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= b ^ {WIDTH{sel}};
            c    <= sel ? 1'b1 : cin;
            cnt  <= '0;
            acc  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            c    <= c_next;
            cnt  <= cnt + 1'b1;
            acc  <= {sum, acc[WIDTH-1:1]};
            if (last) begin
                result <= {sum, acc[WIDTH-1:1]};
                cout   <= c_next;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q;

    // On the last bit, c is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= c ^ c_next;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl (WIDTH=8).
// Inputs are driven and outputs sampled on the falling edge.

module tb_serial_addsub_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sel;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       cout;
    logic       overflow;
    logic       busy;
    logic       done;

    int checks;
    int errors;
    int overlap;

    int lat;
    int bcnt;
    int hold_bad;
    int extra;

`ifdef SERIAL_ADDSUB_OVF_EN
    localparam logic OVF_7F01 = 1'b1;
`else
    localparam logic OVF_7F01 = 1'b0;
`endif

    serial_addsub_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sel      (sel),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after
    // the accepting rising edge.
    task automatic start_op(input logic s, input logic ci,
                            input logic [7:0] av,
                            input logic [7:0] bv);
        start = 1'b1;
        sel   = s;
        cin   = ci;
        a     = av;
        b     = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges (1 = current) until done; returns with
    // done high, or lt=0 if the bound runs out.
    task automatic wait_done(input logic [7:0] held,
                             output int lt,
                             output int bc,
                             output int hb);
        lt = 0;
        bc = 0;
        hb = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy && done) overlap++;
            if (done) begin
                lt = i;
                break;
            end
            if (busy) bc++;
            if (result !== held) hb++;
            @(negedge clk);
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        overlap = 0;
        rst     = 1'b1;
        start   = 1'b0;
        sel     = 1'b0;
        cin     = 1'b0;
        a       = '0;
        b       = '0;

        repeat (2) @(negedge clk);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 0x35 + 0x4A
        start_op(1'b0, 1'b0, 8'h35, 8'h4A);
        wait_done(8'h00, lat, bcnt, hold_bad);
        chk("add1_lat", 32'(lat), 32'd9);
        chk("add1_busy", 32'(bcnt), 32'd8);
        chk("add1_result", 32'(result), 32'h7F);
        chk("add1_cout", 32'(cout), 32'h0);
        chk("add1_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        chk("add1_idle_done", 32'(done), 32'h0);
        chk("add1_idle_busy", 32'(busy), 32'h0);

        // 0x7F + 0x01
        start_op(1'b0, 1'b0, 8'h7F, 8'h01);
        wait_done(8'h7F, lat, bcnt, hold_bad);
        chk("add2_lat", 32'(lat), 32'd9);
        chk("add2_hold", 32'(hold_bad), 32'd0);
        chk("add2_result", 32'(result), 32'h80);
        chk("add2_cout", 32'(cout), 32'h0);
        chk("add2_ovf", 32'(overflow), 32'(OVF_7F01));
        @(negedge clk);

        // 0xFF + 0x01 + 1
        start_op(1'b0, 1'b1, 8'hFF, 8'h01);
        wait_done(8'h80, lat, bcnt, hold_bad);
        chk("add3_lat", 32'(lat), 32'd9);
        chk("add3_result", 32'(result), 32'h01);
        chk("add3_cout", 32'(cout), 32'h1);
        chk("add3_ovf", 32'(overflow), 32'h0);
        @(negedge clk);

        // 0x10 - 0x20, cin set to show it is ignored
        start_op(1'b1, 1'b1, 8'h10, 8'h20);
        wait_done(8'h01, lat, bcnt, hold_bad);
        chk("sub1_lat", 32'(lat), 32'd9);
        chk("sub1_result", 32'(result), 32'hF0);
        chk("sub1_cout", 32'(cout), 32'h0);
        chk("sub1_ovf", 32'(overflow), 32'h0);
        @(negedge clk);

        // 0x50 - 0x10 with a stray start at SHIFT cycle 3
        start_op(1'b1, 1'b0, 8'h50, 8'h10);
        repeat (2) @(negedge clk);
        start = 1'b1;
        sel   = 1'b0;
        a     = 8'hAA;
        b     = 8'h55;
        @(negedge clk);
        start = 1'b0;
        wait_done(8'hF0, lat, bcnt, hold_bad);
        chk("sub2_lat", 32'(lat), 32'd6);
        chk("sub2_result", 32'(result), 32'h40);
        chk("sub2_cout", 32'(cout), 32'h1);
        count_done(12, extra);
        chk("sub2_one_done", 32'(extra), 32'd0);

        // reset at SHIFT cycle 5
        start_op(1'b0, 1'b0, 8'h35, 8'h4A);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_result", 32'(result), 32'h0);
        chk("mid_rst_cout", 32'(cout), 32'h0);
        chk("mid_rst_ovf", 32'(overflow), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        count_done(12, extra);
        chk("mid_rst_no_done", 32'(extra), 32'd0);

        start_op(1'b0, 1'b0, 8'h7F, 8'h01);
        wait_done(8'h00, lat, bcnt, hold_bad);
        chk("post_rst_lat", 32'(lat), 32'd9);
        chk("post_rst_result", 32'(result), 32'h80);
        chk("post_rst_ovf", 32'(overflow), 32'(OVF_7F01));
        @(negedge clk);

        // back-to-back: new start in the DONE cycle
        start_op(1'b1, 1'b0, 8'h50, 8'h10);
        wait_done(8'h80, lat, bcnt, hold_bad);
        chk("b2b_first_lat", 32'(lat), 32'd9);
        chk("b2b_first_result", 32'(result), 32'h40);
        start_op(1'b0, 1'b0, 8'h01, 8'h02);
        wait_done(8'h40, lat, bcnt, hold_bad);
        chk("b2b_second_lat", 32'(lat), 32'd9);
        chk("b2b_hold", 32'(hold_bad), 32'd0);
        chk("b2b_busy", 32'(bcnt), 32'd8);
        chk("b2b_result", 32'(result), 32'h03);
        chk("b2b_cout", 32'(cout), 32'h0);
        @(negedge clk);
        chk("b2b_idle_done", 32'(done), 32'h0);

        chk("busy_done_overlap", 32'(overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
